// File: rtl/text_console_pkg.sv
// Shared constants and types for the text console writer.
package text_console_pkg;

    localparam int         COLS_DEF = 80;
    localparam int         ROWS_DEF = 25;
    localparam logic [7:0] ATTR_DEF = 8'h07;

    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_HT    = 8'h09;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_BLANK = 8'h00;

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        IDLE      = 2'd1,
        WRITE     = 2'd2,
        CLEAR_ROW = 2'd3
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_console_writer_fill.sv
// vram_fill_engine: writes the same word to `count` consecutive addresses
// starting at `base`, one per cycle, then pulses `done` for one cycle.
module vram_fill_engine #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    input  logic [15:0]       word,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic [15:0]       data,
    output logic              done,
    output logic              busy
);

    logic [ADDR_W:0] remaining;

    // Sequence addresses while busy; done pulses the cycle after the last write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr      <= '0;
            we        <= 1'b0;
            data      <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy      <= 1'b1;
                we        <= 1'b1;
                addr      <= base;
                data      <= word;
                remaining <= count - 1'b1;
            end else if (busy) begin
                if (remaining == '0) begin
                    busy <= 1'b0;
                    we   <= 1'b0;
                    done <= 1'b1;
                end else begin
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/text_console_writer.sv
// Text console writer: turns a byte stream into video RAM cell writes with a
// tracked cursor. Optional tab expansion is enabled by TEXT_CONSOLE_TAB_EN.
module text_console_writer
    import text_console_pkg::*;
#(
    parameter int         COLS   = COLS_DEF,
    parameter int         ROWS   = ROWS_DEF,
    parameter logic [7:0] ATTR   = ATTR_DEF,
    parameter int         ADDR_W = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      char_valid,
    input  logic [7:0]                char_data,
    output logic                      char_ready,
    output logic [ADDR_W-1:0]         vram_addr,
    output logic [15:0]               vram_data,
    output logic                      vram_we,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic [$clog2(ROWS)-1:0]   cursor_row
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int CNT_W = ADDR_W + 1;
    localparam int TOTAL = COLS * ROWS;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row, row_nxt;
    logic [ADDR_W-1:0] line_base, base_nxt, cur_addr;
    logic              adv_pending, do_adv;

    logic              wr_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    logic              fill_start, fill_we, fill_done, fill_busy;
    logic [ADDR_W-1:0] fill_base, fill_addr;
    logic [CNT_W-1:0]  fill_cnt;
    logic [15:0]       fill_data;

    assign cur_addr = line_base + ADDR_W'(col);

    // Next row and its base address, wrapping the bottom row back to the top.
    always_comb begin
        row_nxt  = row + 1'b1;
        base_nxt = line_base + ADDR_W'(COLS);
        if (row == LAST_ROW) begin
            row_nxt  = '0;
            base_nxt = '0;
        end
    end

`ifdef TEXT_CONSOLE_TAB_EN
    logic [COL_W:0]   tab_stop;
    logic             tab_wrap;
    logic [CNT_W-1:0] tab_cnt;
    assign tab_stop = {1'b0, col | COL_W'(7)} + 1'b1;
    assign tab_wrap = tab_stop >= (COL_W+1)'(COLS);
    assign tab_cnt  = tab_wrap ? (CNT_W'(COLS) - CNT_W'(col))
                               : (CNT_W'(tab_stop) - CNT_W'(col));
`endif

    // A line advance happens on LF, after writing the last column, or after a
    // wrapping tab fill completes; it also retargets the fill at the new row.
    assign do_adv = (state == IDLE && char_valid && char_data == CHAR_LF)
                 || (state == WRITE && adv_pending)
                 || (state == CLEAR_ROW && fill_done && adv_pending);

    // Kick the fill engine once per fill state entry; `done` blocks a re-kick.
    assign fill_start = (state == CLEAR_ALL || state == CLEAR_ROW) && !fill_busy && !fill_done;

    // Main control: decode bytes in IDLE, sequence writes and fills.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= CLEAR_ALL;
            col         <= '0;
            row         <= '0;
            line_base   <= '0;
            adv_pending <= 1'b0;
            wr_we       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            fill_base   <= '0;
            fill_cnt    <= CNT_W'(TOTAL);
        end else begin
            wr_we <= 1'b0;
            case (state)
                IDLE: if (char_valid) begin
                    case (char_data)
                        CHAR_CR: col <= '0;
                        CHAR_LF: begin
                            col   <= '0;
                            state <= CLEAR_ROW;
                        end
                        CHAR_BS: if (col != '0) begin
                            col     <= col - 1'b1;
                            wr_we   <= 1'b1;
                            wr_addr <= cur_addr - 1'b1;
                            wr_data <= {ATTR, CHAR_BLANK};
                            state   <= WRITE;
                        end
                        CHAR_FF: begin
                            col       <= '0;
                            row       <= '0;
                            line_base <= '0;
                            fill_base <= '0;
                            fill_cnt  <= CNT_W'(TOTAL);
                            state     <= CLEAR_ALL;
                        end
`ifdef TEXT_CONSOLE_TAB_EN
                        CHAR_HT: begin
                            fill_base   <= cur_addr;
                            fill_cnt    <= tab_cnt;
                            col         <= tab_wrap ? '0 : tab_stop[COL_W-1:0];
                            adv_pending <= tab_wrap;
                            state       <= CLEAR_ROW;
                        end
`endif
                        default: if (is_printable(char_data)) begin
                            wr_we   <= 1'b1;
                            wr_addr <= cur_addr;
                            wr_data <= {ATTR, char_data};
                            state   <= WRITE;
                            if (col == LAST_COL) begin
                                col         <= '0;
                                adv_pending <= 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    endcase
                end
                WRITE:     state <= adv_pending ? CLEAR_ROW : IDLE;
                CLEAR_ROW: if (fill_done && !adv_pending) state <= IDLE;
                CLEAR_ALL: if (fill_done) state <= IDLE;
                default:   state <= CLEAR_ALL;
            endcase
            if (do_adv) begin
                row         <= row_nxt;
                line_base   <= base_nxt;
                fill_base   <= base_nxt;
                fill_cnt    <= CNT_W'(COLS);
                adv_pending <= 1'b0;
            end
        end
    end

    vram_fill_engine #(.ADDR_W(ADDR_W)) u_fill (
        .clk   (clk),
        .rst   (rst),
        .start (fill_start),
        .base  (fill_base),
        .count (fill_cnt),
        .word  ({ATTR, CHAR_BLANK}),
        .addr  (fill_addr),
        .we    (fill_we),
        .data  (fill_data),
        .done  (fill_done),
        .busy  (fill_busy)
    );

    assign vram_we    = fill_we | wr_we;
    assign vram_addr  = fill_we ? fill_addr : wr_addr;
    assign vram_data  = fill_we ? fill_data : wr_data;
    assign char_ready = (state == IDLE);
    assign cursor_col = col;
    assign cursor_row = row;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: a cursor model pushes expected cell writes
// into a queue; a monitor pops and compares every vram_we cycle.
module tb_text_console_writer;

    localparam int COLS = 80;
    localparam int ROWS = 25;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic [11:0] vram_addr;
    logic [15:0] vram_data;
    logic        vram_we;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;

    always #5 clk = ~clk;

    text_console_writer dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .vram_we    (vram_we),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    logic [27:0] sb[$];
    int vectors = 0;
    int miscompares = 0;
    int mcol = 0;
    int mrow = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write cycle: ready low, address in range, and matches the next expected cell.
    always @(negedge clk) begin : monitor
        logic [27:0] e;
        if (rst && vram_we) begin
            vectors++;
            assert (char_ready === 1'b0) else begin
                miscompares++;
                $error("FAIL ready_in_write: observed %b expected 0", char_ready);
            end
            vectors++;
            assert (vram_addr < 12'd2000) else begin
                miscompares++;
                $error("FAIL addr_range: observed %0d expected below 2000", vram_addr);
            end
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_write: observed addr %0d data %h expected no write", vram_addr, vram_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                vectors++;
                assert ({vram_addr, vram_data} === e) else begin
                    miscompares++;
                    $error("FAIL cell_write: observed addr %0d data %h expected addr %0d data %h",
                           vram_addr, vram_data, e[27:16], e[15:0]);
                end
            end
        end
    end

    task automatic push(input int addr, input logic [15:0] data);
        sb.push_back({12'(addr), data});
    endtask

    task automatic push_clear_all();
        for (int i = 0; i < COLS * ROWS; i++) push(i, 16'h0700);
    endtask

    task automatic line_adv();
        mrow = (mrow + 1) % ROWS;
        for (int i = 0; i < COLS; i++) push(mrow * COLS + i, 16'h0700);
    endtask

    // Reference behaviour of one consumed byte.
    task automatic model_char(input logic [7:0] c);
        if (c >= 8'h20 && c < 8'h7F) begin
            push(mrow * COLS + mcol, {8'h07, c});
            if (mcol == COLS - 1) begin
                mcol = 0;
                line_adv();
            end else begin
                mcol++;
            end
        end else if (c == 8'h0D) begin
            mcol = 0;
        end else if (c == 8'h0A) begin
            mcol = 0;
            line_adv();
        end else if (c == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                push(mrow * COLS + mcol, 16'h0700);
            end
        end else if (c == 8'h0C) begin
            mcol = 0;
            mrow = 0;
            push_clear_all();
        end
`ifdef TEXT_CONSOLE_TAB_EN
        else if (c == 8'h09) begin
            int stop;
            stop = (mcol / 8 + 1) * 8;
            for (int i = mcol; i < stop && i < COLS; i++) push(mrow * COLS + i, 16'h0700);
            if (stop >= COLS) begin
                mcol = 0;
                line_adv();
            end else begin
                mcol = stop;
            end
        end
`endif
    endtask

    task automatic drive(input logic [7:0] c);
        @(negedge clk);
        char_valid = 1'b1;
        char_data  = c;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        char_data  = 8'h00;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (char_ready === 1'b1 && sb.size() == 0) break;
        end
        chk(tag, {30'd0, char_ready, sb.size() == 0}, 32'd3);
    endtask

    task automatic put(input logic [7:0] c);
        model_char(c);
        drive(c);
        wait_idle("idle_after_byte", 2200);
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_col"}, 32'(cursor_col), 32'(mcol));
        chk({tag, "_row"}, 32'(cursor_row), 32'(mrow));
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(vram_we), 32'd0);
        chk("rst_addr", 32'(vram_addr), 32'd0);
        chk("rst_data", 32'(vram_data), 32'd0);
        chk("rst_ready", 32'(char_ready), 32'd0);
        chk_cursor("rst");

        // Full clear after release
        push_clear_all();
        rst = 1'b1;
        wait_idle("clear_all_done", 2200);
        chk_cursor("after_clear");

        // "Hi"
        put(8'h48);
        chk_cursor("after_H");
        put(8'h69);
        chk_cursor("after_Hi");

        // FF then a full row of 'A' wraps to row 1
        put(8'h0C);
        chk_cursor("after_ff");
        for (int i = 0; i < COLS; i++) put(8'h41);
        chk_cursor("after_80A");

        // BS at col 0, BS at col 5, CR at col 37
        put(8'h08);
        chk_cursor("bs_col0");
        for (int i = 0; i < 5; i++) put(8'h61 + 8'(i));
        put(8'h08);
        chk_cursor("bs_col5");
        while (mcol < 37) put(8'h7A);
        chk_cursor("at_col37");
        put(8'h0D);
        chk_cursor("after_cr");

        // Ignored bytes
        put(8'h61);
        put(8'h62);
        put(8'h01);
        put(8'h7F);
        put(8'h80);
        put(8'hFF);
        chk_cursor("after_ignored");

        // Tab from col 3, then near the right edge
        put(8'h63);
        put(8'h09);
        chk_cursor("tab_col3");
        while (mcol < 75) put(8'h78);
        put(8'h09);
        chk_cursor("tab_edge");

        // LF down to the bottom row, then wrap to the top
        while (mrow != ROWS - 1) put(8'h0A);
        chk_cursor("row24");
        put(8'h0A);
        chk_cursor("lf_wrap");

        // Reset in the middle of a row clear
        model_char(8'h0A);
        drive(8'h0A);
        for (int n = 0; n < 10 && vram_we !== 1'b1; n++) @(negedge clk);
        chk("row_clear_started", 32'(vram_we), 32'd1);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        chk("midclear_we", 32'(vram_we), 32'd0);
        chk("midclear_ready", 32'(char_ready), 32'd0);
        mcol = 0;
        mrow = 0;
        repeat (2) @(negedge clk);
        chk_cursor("midclear_rst");
        push_clear_all();
        rst = 1'b1;
        wait_idle("reclear_done", 2200);
        chk_cursor("after_reclear");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Character-stream front end for the text-mode video RAM write port of vga_display.
- Accepts ASCII bytes over a valid/ready handshake and keeps a cursor.
- Emits one-cycle write strobes with address/data cells {attr, char}.
- Handles clear-on-reset, CR/LF/BS/FF and wrap-around with row clearing; replaces the hard-coded startup fill.

Parameters:
- COLS, 80, characters per row
- ROWS, 25, rows per screen
- ATTR, 8'h07, attribute byte placed in data[15:8] for every write
- ADDR_W, 12, video RAM address width; COLS*ROWS must be at most 2**ADDR_W

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- char_valid  in  1  char_data holds a byte to consume
- char_data  in  8  ASCII byte
- char_ready  out  1  writer can accept a byte this cycle
- vram_addr  out  ADDR_W  cell address (row*COLS + col)
- vram_data  out  16  {ATTR, char}
- vram_we  out  1  write strobe, one cycle per cell
- cursor_col  out  $clog2(COLS)  current column
- cursor_row  out  $clog2(ROWS)  current row

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low; any rst low forces the reset state immediately, including mid-clear or mid-write.
- Reset values: vram_we=0, vram_addr=0, vram_data=0, char_ready=0, cursor=(0,0), state=CLEAR_ALL.
- States: CLEAR_ALL, IDLE, WRITE, CLEAR_ROW.
- CLEAR_ALL:
  - first clock after rst rises, write addr 0, data {ATTR,8'h00}
  - increment the address each cycle through COLS*ROWS-1, with vram_we=1 on every cycle (2000 writes at default)
  - then go to IDLE with cursor=(0,0)
- IDLE:
  - char_ready=1 and vram_we=0
  - handshake fires when char_valid && char_ready in cycle T
  - the byte is decoded at T, and char_ready=0 from T+1
- Printable (0x20..0x7E):
  - WRITE at T+1: vram_we=1, addr = line_base+col, data={ATTR,byte}
  - col advances; at col==COLS-1, col:=0 and a line advance follows
  - with no line advance, return to IDLE at T+2, giving one byte per 2 cycles
- CR 0x0D: col:=0, no write, back to IDLE at T+1.
- LF 0x0A: col:=0 and line advance.
- BS 0x08:
  - if col>0, col:=col-1 and write {ATTR,8'h00} at the new position in WRITE
  - at col 0, no change and no write
- FF 0x0C: enter CLEAR_ALL, then cursor=(0,0).
- Other bytes below 0x20 and bytes 0x7F..0xFF: consumed and ignored, ready again at T+1.
- Line advance:
  - row:=(row+1) mod ROWS, so row ROWS-1 wraps to 0
  - then CLEAR_ROW writes COLS blank cells of the new row, addresses line_base..line_base+COLS-1, one per cycle
  - then return to IDLE
- Addressing arithmetic: keep line_base as a register, incremented by COLS and reset to 0 on wrap. No multiplier. Addresses never exceed COLS*ROWS-1.
- char_ready is 0 throughout WRITE, CLEAR_ROW and CLEAR_ALL; char_valid is ignored then, and the upstream must hold the byte.

Optional Feature:
- Macro: TEXT_CONSOLE_TAB_EN.
- With it defined, HT 0x09 writes blanks from col up to the next multiple of 8, one per cycle. If that passes COLS-1, col wraps to 0 with a line advance. A tab at col 7 writes one blank and leaves col=8.
- Without it, 0x09 is ignored like other control bytes.

Decomposition:
- Package text_console_pkg:
  - default COLS/ROWS/ATTR
  - ASCII constants CHAR_CR, CHAR_LF, CHAR_BS, CHAR_FF, CHAR_HT, CHAR_BLANK
  - state enum typedef
- One sub-module, vram_fill_engine:
  - inputs: start, base address, count, data word
  - outputs: sequential addr/we plus a done pulse
  - shared by CLEAR_ALL, CLEAR_ROW and tab fill

Test Plan:
- Reset release -> exactly 2000 consecutive vram_we cycles, addr 0..1999, all data 16'h0700, then char_ready=1 and cursor=(0,0).
- Send "Hi" -> writes addr 0 data 16'h0748, then addr 1 data 16'h0769; cursor_col=2; char_ready low in each write cycle.
- Send 80 'A' from (0,0) -> last write addr 79; then CLEAR_ROW writes 80..159 with 16'h0700; cursor=(1,0).
- Cursor at row 24, send LF -> cursor row 0, col 0; CLEAR_ROW writes addr 0..79 blank; no address reaches 2000 or more.
- BS at col 0 produces no write. At col 5, BS writes addr line_base+4 with 16'h0700 and sets col=4. CR at col 37 sets col=0 with no write.
- Reset mid-clear: assert rst during CLEAR_ROW -> vram_we drops to 0 asynchronously; after release, the full 2000-cell clear restarts from addr 0. With TEXT_CONSOLE_TAB_EN, HT at col 3 writes addr 3..7 blank, giving col=8.
